// File: rtl/video_pkg.sv
// Video timing definitions shared by the scanout path: derived line/frame totals
// and sync windows, plus the default 640x480 mode.
package video_pkg;

    typedef struct packed {
        int unsigned h_total;
        int unsigned v_total;
        int unsigned h_sync_start;
        int unsigned h_sync_end;
        int unsigned v_sync_start;
        int unsigned v_sync_end;
    } video_timing_t;

    // Region order is active, front porch, sync, back porch on both axes.
    function automatic video_timing_t calc_timing(
        input int unsigned h_act,
        input int unsigned h_fp,
        input int unsigned h_sync,
        input int unsigned h_bp,
        input int unsigned v_act,
        input int unsigned v_fp,
        input int unsigned v_sync,
        input int unsigned v_bp
    );
        video_timing_t t;
        t.h_total      = h_act + h_fp + h_sync + h_bp;
        t.v_total      = v_act + v_fp + v_sync + v_bp;
        t.h_sync_start = h_act + h_fp;
        t.h_sync_end   = h_act + h_fp + h_sync;
        t.v_sync_start = v_act + v_fp;
        t.v_sync_end   = v_act + v_fp + v_sync;
        return t;
    endfunction

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam video_timing_t DEF_TIMING = calc_timing(
        DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP,
        DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

    localparam int unsigned H_TOTAL      = DEF_TIMING.h_total;
    localparam int unsigned V_TOTAL      = DEF_TIMING.v_total;
    localparam int unsigned H_SYNC_START = DEF_TIMING.h_sync_start;
    localparam int unsigned H_SYNC_END   = DEF_TIMING.h_sync_end;
    localparam int unsigned V_SYNC_START = DEF_TIMING.v_sync_start;
    localparam int unsigned V_SYNC_END   = DEF_TIMING.v_sync_end;

endpackage

// File: rtl/framebuffer_scanout_if.sv
// Read port between the scanout engine and the framebuffer memory, including the
// index of the buffer currently being displayed.
interface framebuffer_scanout_if #(
    parameter int ADDR_W = 19
);
    logic              rd_buf;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_data;

    modport master (
        output rd_buf,
        output rd_en,
        output rd_addr,
        input  rd_data
    );

    modport slave (
        input  rd_buf,
        input  rd_en,
        input  rd_addr,
        output rd_data
    );
endinterface

// File: rtl/video_timing_gen.sv
// Horizontal/vertical position counters and the stage-0 active and sync flags
// decoded from them.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int unsigned HOR_ACTIVE_PIXELS = DEF_H_ACTIVE,
    parameter int unsigned HOR_FRONT_PORCH   = DEF_H_FP,
    parameter int unsigned HOR_SYNC          = DEF_H_SYNC,
    parameter int unsigned HOR_BACK_PORCH    = DEF_H_BP,
    parameter int unsigned VER_ACTIVE_PIXELS = DEF_V_ACTIVE,
    parameter int unsigned VER_FRONT_PORCH   = DEF_V_FP,
    parameter int unsigned VER_SYNC          = DEF_V_SYNC,
    parameter int unsigned VER_BACK_PORCH    = DEF_V_BP,
    parameter logic        SYNC_ACTIVE_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    output logic active,
    output logic hsync,
    output logic vsync,
    output logic frame_end,
    output logic blank_start
);

    localparam video_timing_t TIMING = calc_timing(
        HOR_ACTIVE_PIXELS, HOR_FRONT_PORCH, HOR_SYNC, HOR_BACK_PORCH,
        VER_ACTIVE_PIXELS, VER_FRONT_PORCH, VER_SYNC, VER_BACK_PORCH);

    localparam int H_W = $clog2(TIMING.h_total);
    localparam int V_W = $clog2(TIMING.v_total);

    localparam logic [H_W-1:0] H_LAST   = H_W'(TIMING.h_total - 1);
    localparam logic [V_W-1:0] V_LAST   = V_W'(TIMING.v_total - 1);
    localparam logic [H_W-1:0] H_ACT    = H_W'(HOR_ACTIVE_PIXELS);
    localparam logic [V_W-1:0] V_ACT    = V_W'(VER_ACTIVE_PIXELS);
    localparam logic [H_W-1:0] HS_START = H_W'(TIMING.h_sync_start);
    localparam logic [H_W-1:0] HS_END   = H_W'(TIMING.h_sync_end);
    localparam logic [V_W-1:0] VS_START = V_W'(TIMING.v_sync_start);
    localparam logic [V_W-1:0] VS_END   = V_W'(TIMING.v_sync_end);

    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;
    logic           h_wrap;

    assign h_wrap = (h_cnt == H_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (ce) begin
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);

    assign hsync = ((h_cnt >= HS_START) && (h_cnt < HS_END)) ? SYNC_ACTIVE_LEVEL
                                                             : ~SYNC_ACTIVE_LEVEL;
    assign vsync = ((v_cnt >= VS_START) && (v_cnt < VS_END)) ? SYNC_ACTIVE_LEVEL
                                                             : ~SYNC_ACTIVE_LEVEL;

    // Last position of the frame; the address counter restarts from here.
    assign frame_end = h_wrap && (v_cnt == V_LAST);

    // First pixel of the first blank line: all active reads are already issued.
    assign blank_start = (h_cnt == '0) && (v_cnt == V_ACT);

endmodule

// File: rtl/framebuffer_scanout.sv
// Framebuffer reader: sequential read addresses for the active area, two-stage
// output pipeline, and double-buffer selection at the start of vertical blank.
module framebuffer_scanout
    import video_pkg::*;
#(
    parameter int unsigned HOR_ACTIVE_PIXELS = DEF_H_ACTIVE,
    parameter int unsigned HOR_FRONT_PORCH   = DEF_H_FP,
    parameter int unsigned HOR_SYNC          = DEF_H_SYNC,
    parameter int unsigned HOR_BACK_PORCH    = DEF_H_BP,
    parameter int unsigned VER_ACTIVE_PIXELS = DEF_V_ACTIVE,
    parameter int unsigned VER_FRONT_PORCH   = DEF_V_FP,
    parameter int unsigned VER_SYNC          = DEF_V_SYNC,
    parameter int unsigned VER_BACK_PORCH    = DEF_V_BP,
    parameter logic        SYNC_ACTIVE_LEVEL = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  render_done,
    output logic                  swap,
    framebuffer_scanout_if.master fb,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  de,
    output logic                  pixel
);

    localparam int unsigned N_PIX = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS;
    localparam int          ADDR_W = $clog2(N_PIX);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N_PIX - 1);

    logic active0;
    logic hsync0;
    logic vsync0;
    logic frame_end;
    logic blank_start;

    video_timing_gen #(
        .HOR_ACTIVE_PIXELS (HOR_ACTIVE_PIXELS),
        .HOR_FRONT_PORCH   (HOR_FRONT_PORCH),
        .HOR_SYNC          (HOR_SYNC),
        .HOR_BACK_PORCH    (HOR_BACK_PORCH),
        .VER_ACTIVE_PIXELS (VER_ACTIVE_PIXELS),
        .VER_FRONT_PORCH   (VER_FRONT_PORCH),
        .VER_SYNC          (VER_SYNC),
        .VER_BACK_PORCH    (VER_BACK_PORCH),
        .SYNC_ACTIVE_LEVEL (SYNC_ACTIVE_LEVEL)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .active      (active0),
        .hsync       (hsync0),
        .vsync       (vsync0),
        .frame_end   (frame_end),
        .blank_start (blank_start)
    );

    logic [ADDR_W-1:0] addr_cnt;

    // Saturates on the last pixel so the porch/blank positions never run past
    // the buffer; cleared as the frame wraps back to (0,0).
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_cnt <= '0;
        end else if (ce) begin
            if (frame_end) begin
                addr_cnt <= '0;
            end else if (active0 && (addr_cnt != ADDR_LAST)) begin
                addr_cnt <= addr_cnt + 1'b1;
            end
        end
    end

    logic rd_buf_q;

    assign swap = ce && blank_start && render_done && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_buf_q <= 1'b0;
        end else if (swap) begin
            rd_buf_q <= ~rd_buf_q;
        end
    end

    logic              rd_en_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              de1;
    logic              hs1;
    logic              vs1;

    // rd_en is a single-clk strobe regardless of how sparse ce is.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            de1       <= 1'b0;
            hs1       <= ~SYNC_ACTIVE_LEVEL;
            vs1       <= ~SYNC_ACTIVE_LEVEL;
        end else begin
            rd_en_q <= ce && active0;
            if (ce) begin
                rd_addr_q <= addr_cnt;
                de1       <= active0;
                hs1       <= hsync0;
                vs1       <= vsync0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            de    <= 1'b0;
            pixel <= 1'b0;
            hsync <= ~SYNC_ACTIVE_LEVEL;
            vsync <= ~SYNC_ACTIVE_LEVEL;
        end else if (ce) begin
            de    <= de1;
            pixel <= de1 ? fb.rd_data : 1'b0;
            hsync <= hs1;
            vsync <= vs1;
        end
    end

    assign fb.rd_buf  = rd_buf_q;
    assign fb.rd_en   = rd_en_q;
    assign fb.rd_addr = rd_addr_q;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Scanout bench on a 12x7 mode: directed swap scenarios plus random ce/reset/
// render_done, all compared against a position-based reference model.
module tb_framebuffer_scanout;

    localparam int HA = 8, HFP = 1, HS = 2, HBP = 1;
    localparam int VA = 4, VFP = 1, VS = 1, VBP = 1;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam int AW = $clog2(HA * VA);

    logic clk = 1'b0;
    logic rst, ce, render_done;
    logic swap, hsync, vsync, de, pixel;

    framebuffer_scanout_if #(.ADDR_W(AW)) fb ();

    framebuffer_scanout #(
        .HOR_ACTIVE_PIXELS (HA),
        .HOR_FRONT_PORCH   (HFP),
        .HOR_SYNC          (HS),
        .HOR_BACK_PORCH    (HBP),
        .VER_ACTIVE_PIXELS (VA),
        .VER_FRONT_PORCH   (VFP),
        .VER_SYNC          (VS),
        .VER_BACK_PORCH    (VBP),
        .SYNC_ACTIVE_LEVEL (1'b0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .render_done (render_done),
        .swap        (swap),
        .fb          (fb),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .pixel       (pixel)
    );

    always #5 clk = ~clk;

    // Memory: data follows the address while rd_en is high, then holds.
    logic mem_hold = 1'b0;
    always @(posedge clk) if (fb.rd_en) mem_hold <= fb.rd_addr[0];
    assign fb.rd_data = fb.rd_en ? fb.rd_addr[0] : mem_hold;

    int n_checks = 0;
    int n_errors = 0;
    int n_swaps  = 0;

    // Reference model: frame position index, plus positions captured 1 and 2 ce ago.
    int pos = 0;
    int p1_pos = 0, p2_pos = 0;
    bit p1_v = 1'b0, p2_v = 1'b0;
    bit m_rd_en = 1'b0;
    bit m_rd_buf = 1'b0;

    function automatic bit in_active(int p);
        return ((p % HT) < HA) && ((p / HT) < VA);
    endfunction

    function automatic int pix_addr(int p);
        return (p / HT) * HA + (p % HT);
    endfunction

    function automatic bit h_sync_on(int p);
        return ((p % HT) >= HA + HFP) && ((p % HT) < HA + HFP + HS);
    endfunction

    function automatic bit v_sync_on(int p);
        return ((p / HT) >= VA + VFP) && ((p / HT) < VA + VFP + VS);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic step(input bit ce_v, input bit rst_v, input bit rdone_v);
        bit exp_de;
        bit exp_swap;
        ce = ce_v;
        rst = rst_v;
        render_done = rdone_v;
        #1;
        exp_de = p2_v && in_active(p2_pos);
        check_val("de", de, exp_de);
        check_val("pixel", pixel, exp_de ? (pix_addr(p2_pos) % 2) : 0);
        check_val("hsync", hsync, (p2_v && h_sync_on(p2_pos)) ? 0 : 1);
        check_val("vsync", vsync, (p2_v && v_sync_on(p2_pos)) ? 0 : 1);
        check_val("rd_en", fb.rd_en, m_rd_en);
        if (m_rd_en) check_val("rd_addr", fb.rd_addr, pix_addr(p1_pos));
        check_val("rd_buf", fb.rd_buf, m_rd_buf);
        exp_swap = ce_v && !rst_v && rdone_v && (pos == VA * HT);
        check_val("swap", swap, exp_swap);
        if (swap) n_swaps++;
        @(posedge clk);
        if (rst_v) begin
            pos = 0; p1_v = 0; p2_v = 0; m_rd_en = 0; m_rd_buf = 0;
        end else begin
            m_rd_en = ce_v && in_active(pos);
            if (exp_swap) m_rd_buf = !m_rd_buf;
            if (ce_v) begin
                p2_v = p1_v; p2_pos = p1_pos;
                p1_v = 1'b1; p1_pos = pos;
                pos = (pos + 1) % FRAME;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        ce = 1'b0;
        rst = 1'b1;
        render_done = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);

        // render_done held: one swap per frame, buffer alternates.
        n_swaps = 0;
        for (int i = 0; i < 3 * FRAME; i++) step(1'b1, 1'b0, 1'b1);
        check_val("swaps_held", n_swaps, 3);
        check_val("rd_buf_after3", fb.rd_buf, 1);

        // Reset at line 2 pixel 5.
        for (int i = 0; i < 2 * HT + 5; i++) step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        check_val("rd_buf_reset", fb.rd_buf, 0);

        // No swap at end of frame 1; render_done raised in frame-2 active area.
        n_swaps = 0;
        for (int i = 0; i < FRAME + 30; i++) step(1'b1, 1'b0, 1'b0);
        check_val("swaps_none", n_swaps, 0);
        for (int i = 0; i < FRAME - 30; i++) step(1'b1, 1'b0, 1'b1);
        check_val("swaps_late", n_swaps, 1);

        // ce every third clk.
        step(1'b1, 1'b1, 1'b0);
        n_swaps = 0;
        for (int i = 0; i < 2 * FRAME * 3; i++) step(i % 3 == 0, 1'b0, 1'b1);
        check_val("swaps_ce3", n_swaps, 2);

        // Random ce, render_done and occasional reset.
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0,
                 $urandom_range(0, 1) == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/framebuffer_scanout.md
Name: framebuffer_scanout

Overview:
- Reader side of the 1-bit monochrome framebuffer that the frame renderer writes.
- Generates VGA-style timing, issues sequential read addresses during the active area, and drives pixel, sync and data-enable outputs.
- Owns buffer selection: at vertical-blank start it either flips the displayed buffer (pulsing `swap` to the renderer) or repeats the current one.

Parameters:
- HOR_ACTIVE_PIXELS, 640, visible pixels per line
- HOR_FRONT_PORCH, 16, pixel periods
- HOR_SYNC, 96, pixel periods
- HOR_BACK_PORCH, 48, pixel periods
- VER_ACTIVE_PIXELS, 480, visible lines
- VER_FRONT_PORCH, 10, lines
- VER_SYNC, 2, lines
- VER_BACK_PORCH, 33, lines
- SYNC_ACTIVE_LEVEL, 1'b0, level of hsync/vsync during the sync pulse

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ce  in  1  pixel-rate clock enable; all state advances only when ce=1
- render_done  in  1  level; renderer has finished the back buffer and waits for swap
- swap  out  1  one-clk pulse: buffers exchanged, renderer may start the next frame
- rd_buf  out  1  buffer index currently scanned out; renderer writes !rd_buf
- rd_en  out  1  read strobe to framebuffer
- rd_addr  out  $clog2(HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS)  pixel address within rd_buf
- rd_data  in  1  pixel from memory
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  data enable (active area)
- pixel  out  1  pixel value, 0 when de=0

Behaviour:
- Totals: H_TOTAL = sum of the four horizontal parameters; V_TOTAL = sum of the four vertical parameters.
  - h_cnt is $clog2(H_TOTAL) wide; v_cnt is $clog2(V_TOTAL) wide.
  - Order within a line/frame: active, front porch, sync, back porch.
- Counters (stage 0), per ce:
  - h_cnt increments and wraps H_TOTAL-1 -> 0.
  - On that wrap v_cnt increments and wraps V_TOTAL-1 -> 0.
- Active flag: active0 = (h_cnt < HOR_ACTIVE_PIXELS) && (v_cnt < VER_ACTIVE_PIXELS).
- Address generation: running counter, no multiplier.
  - addr_cnt resets to 0 when h_cnt=0 and v_cnt=0.
  - It increments after each active pixel.
  - It never exceeds HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS-1.
- Stage 1 (registered on ce):
  - rd_addr <= addr_cnt.
  - rd_en <= active0, and rd_en is asserted only for one clk, in the clk following a ce cycle.
  - Sync and active flags are delayed alongside.
- Memory contract: rd_data is valid 1 clk after rd_en and held until the next rd_en.
- Stage 2 (registered on ce):
  - pixel <= de1 ? rd_data : 0.
  - de, hsync and vsync are taken from the stage-1 delayed copies.
  - Total latency from counter position to outputs is 2 ce cycles, and sync, de and pixel are mutually aligned.
- Sync levels:
  - hsync = SYNC_ACTIVE_LEVEL when HOR_ACTIVE_PIXELS+HOR_FRONT_PORCH <= h_cnt < that +HOR_SYNC; otherwise the inverse.
  - vsync is defined the same way on v_cnt.
- Swap decision: evaluated on the ce cycle where h_cnt=0 and v_cnt=VER_ACTIVE_PIXELS (first blank line).
  - If render_done=1: rd_buf toggles and swap is 1 for exactly that clk.
  - Otherwise rd_buf holds, no pulse, and the same buffer is shown again. There is no retry until the next frame's decision point.
  - render_done rising at any other time has no effect until the next decision point.
- Buffer stability: rd_buf never changes while any active-area read is in flight. The decision point is after the last active read has completed.
- ce=0: all registers hold; swap is 0.
- Reset mid-frame takes effect on the next clk edge. The next frame starts at h_cnt=0, v_cnt=0; the first valid pixel appears after 2 ce.
- Reset values:
  - h_cnt=0, v_cnt=0, addr_cnt=0, rd_buf=0.
  - swap=0, rd_en=0, rd_addr=0, de=0, pixel=0.
  - hsync and vsync at the inactive level (~SYNC_ACTIVE_LEVEL).

Decomposition:
- Package video_pkg holds:
  - the timing localparams (H_TOTAL, V_TOTAL, sync start/end);
  - a function computing them from the parameters;
  - a default-mode constant set for 640x480.
- Sub-module video_timing_gen: h_cnt/v_cnt counters plus active, hsync and vsync flags at stage 0.
- framebuffer_scanout adds address generation, the buffer/swap logic and the output pipeline.

Test Plan:
- Small mode: H 8/1/2/1 (H_TOTAL 12), V 4/1/1/1 (V_TOTAL 7), ce=1 always.
- Timing check, after reset -> de=1 for 8 clk of every 12 on 4 lines, then 0 for 3 lines.
  - hsync is low at clk 9..10 of each line, offset +2.
  - vsync is low on line 5.
  - Frame period is 84 clk.
- Addressing: memory model returns rd_data = addr[0] -> pixel sequence 0,1,0,1,… and rd_addr covers 0..31 once per frame in order; de=0 implies pixel=0.
- Swap with render_done=1 held -> swap pulses once per frame at clk index 48 (line 4, h 0); rd_buf alternates 0,1,0.
- Swap with render_done=0 for frame 1, then raised mid-frame 2 active area -> no swap at the end of frame 1; swap at the frame-2 decision point; rd_buf stays 0 until then.
- ce=1 every 3rd clk -> identical output sequence, stretched 3x; swap is still 1 clk wide; rd_en appears once per active ce.
- rst asserted at line 2 pixel 5 for 1 clk -> outputs at reset values next clk; rd_buf returns to 0; first pixel (addr 0) appears 2 ce after rst deasserts.
